// File: rtl/param_dmem_pkg.sv
// Shared definitions for the lane data-memory port: subword geometry,
// request length / direction codes, FSM states and the load extender.
package param_dmem_pkg;

   localparam int P_NBITS   = 4;
   localparam int C_N_OFF   = 8;
   localparam int C_OFFBITS = 3;
   localparam int ADDR_W    = 32;
   localparam int WORD_W    = P_NBITS * C_N_OFF;

   localparam logic [1:0] LEN_WORD = 2'd0;
   localparam logic [1:0] LEN_BYTE = 2'd1;
   localparam logic [1:0] LEN_HALF = 2'd2;

   localparam logic RW_LD = 1'b0;
   localparam logic RW_ST = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Sign/zero-extend a load response; len code 3 behaves like a word.
   function automatic logic [WORD_W-1:0] load_extend(
      input logic [WORD_W-1:0] data,
      input logic [1:0]        len,
      input logic              is_unsigned
   );
      logic [WORD_W-1:0] result;
      logic              fill;
      result = data;
      fill   = 1'b0;
      case (len)
         LEN_BYTE: begin
            fill   = data[7] & ~is_unsigned;
            result = {{(WORD_W-8){fill}}, data[7:0]};
         end
         LEN_HALF: begin
            fill   = data[15] & ~is_unsigned;
            result = {{(WORD_W-16){fill}}, data[15:0]};
         end
         default: begin
            result = data;
         end
      endcase
      return result;
   endfunction

endpackage

// File: rtl/param_lane_dmem_port_if.sv
// Data-memory request/response bundle. The port drives it as master,
// the memory (or a bench model) answers as slave.
interface param_lane_dmem_port_if;
   import param_dmem_pkg::*;

   logic              dmemreq_val;
   logic              dmemreq_rdy;
   logic              dmemreq_msg_rw;
   logic [1:0]        dmemreq_msg_len;
   logic [ADDR_W-1:0] dmemreq_msg_addr;
   logic [WORD_W-1:0] dmemreq_msg_data;
   logic              dmemresp_val;
   logic              dmemresp_rdy;
   logic [WORD_W-1:0] dmemresp_msg_data;

   modport master (
      output dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr, dmemreq_msg_data,
      input  dmemreq_rdy,
      input  dmemresp_val, dmemresp_msg_data,
      output dmemresp_rdy
   );

   modport slave (
      input  dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr, dmemreq_msg_data,
      output dmemreq_rdy,
      output dmemresp_val, dmemresp_msg_data,
      input  dmemresp_rdy
   );
endinterface

// File: rtl/param_subword_buf.sv
// 32-bit word buffer seen by the lane as eight 4-bit subwords: one nibble
// write port, one nibble read mux, and a full-word load path.
module param_subword_buf
   import param_dmem_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 nib_we,
   input  logic [C_OFFBITS-1:0] nib_off,
   input  logic [P_NBITS-1:0]   nib_in,
   input  logic                 word_we,
   input  logic [WORD_W-1:0]    word_in,
   input  logic [C_OFFBITS-1:0] rd_off,
   output logic [P_NBITS-1:0]   rd_nib,
   output logic [WORD_W-1:0]    word_out
);

   logic [C_N_OFF-1:0][P_NBITS-1:0] buf_r;

   // Word load has priority; the port never asserts both writes together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_r <= '0;
      end else if (word_we) begin
         buf_r <= word_in;
      end else if (nib_we) begin
         buf_r[nib_off] <= nib_in;
      end
   end

   assign rd_nib   = buf_r[rd_off];
   assign word_out = buf_r;

endmodule

// File: rtl/param_lane_dmem_port.sv
// Memory-side partner of the SIMD lane: gathers store subwords into a word,
// issues one val/rdy memory request per start pulse and returns the
// (extended) load word to the lane a subword at a time.
module param_lane_dmem_port
   import param_dmem_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   st_nib_en,
   input  logic [C_OFFBITS-1:0]   st_off,
   input  logic [P_NBITS-1:0]     st_nib,
   input  logic [C_OFFBITS-1:0]   ld_off,
   output logic [P_NBITS-1:0]     ld_nib,
   input  logic                   req_start,
   input  logic                   req_rw,
   input  logic [1:0]             req_len,
   input  logic                   req_unsigned,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   busy,
   output logic                   done,
   param_lane_dmem_port_if.master dmem
);

   state_e            state_r;
   state_e            state_s;
   logic              rw_r;
   logic [1:0]        len_r;
   logic [ADDR_W-1:0] addr_r;
   logic              uns_r;
   logic              busy_r;
   logic              done_r;
   logic              req_val_r;
   logic              resp_rdy_r;
   logic              nib_we_s;
   logic              word_we_s;
   logic [WORD_W-1:0] word_in_s;
   logic [WORD_W-1:0] word_out_s;

   param_subword_buf u_buf (
      .clk      (clk),
      .reset    (reset),
      .nib_we   (nib_we_s),
      .nib_off  (st_off),
      .nib_in   (st_nib),
      .word_we  (word_we_s),
      .word_in  (word_in_s),
      .rd_off   (ld_off),
      .rd_nib   (ld_nib),
      .word_out (word_out_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; starts outside IDLE are dropped, not queued.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_start) state_s = ST_REQ;
            else           state_s = ST_IDLE;
         end
         ST_REQ: begin
            if (dmem.dmemreq_rdy) state_s = ST_WAIT;
            else                  state_s = ST_REQ;
         end
         ST_WAIT: begin
            if (dmem.dmemresp_val) state_s = ST_DONE;
            else                   state_s = ST_WAIT;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Buffer write enables: lane nibbles only while no request is in flight,
   // so the outgoing message data cannot change under the memory.
   always_comb begin
      nib_we_s  = 1'b0;
      word_we_s = 1'b0;
      word_in_s = load_extend(dmem.dmemresp_msg_data, len_r, uns_r);
      if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
         nib_we_s = st_nib_en;
      end else begin
         nib_we_s = 1'b0;
      end
      if ((state_r == ST_WAIT) && dmem.dmemresp_val && (rw_r == RW_LD)) begin
         word_we_s = 1'b1;
      end else begin
         word_we_s = 1'b0;
      end
   end

   // Request attribute latches, captured on an accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw_r   <= 1'b0;
         len_r  <= 2'd0;
         addr_r <= '0;
         uns_r  <= 1'b0;
      end else if ((state_r == ST_IDLE) && req_start) begin
         rw_r   <= req_rw;
         len_r  <= req_len;
         addr_r <= req_addr;
         uns_r  <= req_unsigned;
      end
   end

   // Handshake/status outputs registered from the next state so they line
   // up exactly with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         req_val_r  <= 1'b0;
         resp_rdy_r <= 1'b0;
      end else begin
         busy_r     <= (state_s == ST_REQ) || (state_s == ST_WAIT);
         done_r     <= (state_s == ST_DONE);
         req_val_r  <= (state_s == ST_REQ);
         resp_rdy_r <= (state_s == ST_WAIT);
      end
   end

   assign busy                  = busy_r;
   assign done                  = done_r;
   assign dmem.dmemreq_val      = req_val_r;
   assign dmem.dmemresp_rdy     = resp_rdy_r;
   assign dmem.dmemreq_msg_rw   = rw_r;
   assign dmem.dmemreq_msg_len  = len_r;
   assign dmem.dmemreq_msg_addr = addr_r;
   assign dmem.dmemreq_msg_data = word_out_s;

endmodule

// File: tb/tb_param_lane_dmem_port.sv
// Self-checking bench for param_lane_dmem_port: table of memory accesses
// plus hand-written backpressure, early-response, same-cycle and reset cases.
module tb_param_lane_dmem_port;
   import param_dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_nib_en;
   logic [2:0]  st_off;
   logic [3:0]  st_nib;
   logic [2:0]  ld_off;
   logic [3:0]  ld_nib;
   logic        req_start;
   logic        req_rw;
   logic [1:0]  req_len;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic        busy;
   logic        done;

   param_lane_dmem_port_if dmem ();

   param_lane_dmem_port dut (
      .clk          (clk),
      .reset        (reset),
      .st_nib_en    (st_nib_en),
      .st_off       (st_off),
      .st_nib       (st_nib),
      .ld_off       (ld_off),
      .ld_nib       (ld_nib),
      .req_start    (req_start),
      .req_rw       (req_rw),
      .req_len      (req_len),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .busy         (busy),
      .done         (done),
      .dmem         (dmem)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic        rw;
      logic [1:0]  len;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] resp;
      logic [31:0] exp_word;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_buf(output logic [31:0] w);
      for (int i = 0; i < 8; i++) begin
         ld_off = 3'(i);
         #1;
         w[i*4 +: 4] = ld_nib;
      end
      ld_off = 3'd0;
   endtask

   task automatic nib_write(input logic [2:0] off, input logic [3:0] val);
      st_nib_en = 1'b1;
      st_off    = off;
      st_nib    = val;
      step();
      st_nib_en = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic sb_pop_check(input string tag);
      logic [31:0] w;
      logic [31:0] e;
      read_buf(w);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else                 e = 32'hxxxx_xxxx;
      check({tag, "_buffer"}, w, e);
   endtask

   task automatic start_req(input logic rw, input logic [1:0] len, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp_word);
      req_rw       = rw;
      req_len      = len;
      req_unsigned = uns;
      req_addr     = addr;
      req_start    = 1'b1;
      sb_q.push_back(exp_word);
      step();
      req_start    = 1'b0;
   endtask

   task automatic run_access(input vec_t v, input string tag);
      int n;
      dmem.dmemreq_rdy  = 1'b1;
      dmem.dmemresp_val = 1'b0;
      start_req(v.rw, v.len, v.uns, v.addr, v.exp_word);
      check({tag, "_req_val"},  {31'd0, dmem.dmemreq_val}, 32'd1);
      check({tag, "_req_addr"}, dmem.dmemreq_msg_addr, v.addr);
      check({tag, "_req_len"},  {30'd0, dmem.dmemreq_msg_len}, {30'd0, v.len});
      check({tag, "_req_rw"},   {31'd0, dmem.dmemreq_msg_rw}, {31'd0, v.rw});
      if (v.chk_data) check({tag, "_req_data"}, dmem.dmemreq_msg_data, v.exp_data);
      dmem.dmemresp_val      = 1'b1;
      dmem.dmemresp_msg_data = v.resp;
      wait_done(tag, n);
      check({tag, "_latency"}, 32'(n + 1), 32'd3);
      dmem.dmemresp_val = 1'b0;
      sb_pop_check(tag);
      step();
      check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      logic [31:0] held_addr;
      vec_t        v;
      int          n;

      reset = 1'b0;
      st_nib_en = 1'b0; st_off = 3'd0; st_nib = 4'd0; ld_off = 3'd0;
      req_start = 1'b0; req_rw = 1'b0; req_len = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0;
      dmem.dmemreq_rdy = 1'b0; dmem.dmemresp_val = 1'b0; dmem.dmemresp_msg_data = 32'd0;

      // Reset state
      step(); step();
      check("rst_outputs", {28'd0, busy, done, dmem.dmemreq_val, dmem.dmemresp_rdy}, 32'd0);
      check("rst_ld_nib", {28'd0, ld_nib}, 32'd0);
      read_buf(w);
      check("rst_buffer", w, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Store word built from nibbles 1..8
      for (int i = 0; i < 8; i++) nib_write(3'(i), 4'(i + 1));
      v = '{rw: RW_ST, len: LEN_WORD, uns: 1'b0, addr: 32'h100, resp: 32'hFFFF_FFFF,
            exp_word: 32'h8765_4321, chk_data: 1'b1, exp_data: 32'h8765_4321};
      run_access(v, "store_word");

      // Backpressure: rdy low 5 cycles, nibble writes and second start ignored
      dmem.dmemreq_rdy = 1'b0;
      start_req(RW_ST, LEN_WORD, 1'b0, 32'h300, 32'h8765_4321);
      held_addr = 32'h300;
      for (int k = 0; k < 5; k++) begin
         check("bp_val_busy", {30'd0, dmem.dmemreq_val, busy}, 32'd3);
         check("bp_addr", dmem.dmemreq_msg_addr, held_addr);
         check("bp_data", dmem.dmemreq_msg_data, 32'h8765_4321);
         st_nib_en = 1'b1; st_off = 3'(k); st_nib = 4'h0;
         req_start = 1'b1; req_addr = 32'h400; req_rw = RW_LD;
         step();
      end
      st_nib_en = 1'b0; req_start = 1'b0;
      dmem.dmemreq_rdy = 1'b1;
      dmem.dmemresp_val = 1'b1; dmem.dmemresp_msg_data = 32'h0;
      wait_done("bp", n);
      dmem.dmemresp_val = 1'b0;
      check("bp_rw_held", {31'd0, dmem.dmemreq_msg_rw}, 32'd1);
      sb_pop_check("bp");
      step();
      check("bp_no_queue", {30'd0, busy, dmem.dmemreq_val}, 32'd0);
      step();
      check("bp_still_idle", {31'd0, busy}, 32'd0);

      // Table-driven accesses
      tbl[0] = '{RW_LD, LEN_BYTE, 1'b0, 32'h10, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0, 32'h0};
      tbl[1] = '{RW_LD, LEN_BYTE, 1'b1, 32'h11, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 32'h0};
      tbl[2] = '{RW_LD, LEN_HALF, 1'b0, 32'h12, 32'h1234_8001, 32'hFFFF_8001, 1'b0, 32'h0};
      tbl[3] = '{RW_LD, LEN_HALF, 1'b1, 32'h14, 32'hABCD_8001, 32'h0000_8001, 1'b0, 32'h0};
      tbl[4] = '{RW_LD, LEN_WORD, 1'b0, 32'h18, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0};
      tbl[5] = '{RW_LD, 2'd3,     1'b0, 32'h1C, 32'h8000_0080, 32'h8000_0080, 1'b0, 32'h0};
      tbl[6] = '{RW_LD, LEN_BYTE, 1'b0, 32'h20, 32'h1234_567F, 32'h0000_007F, 1'b0, 32'h0};
      tbl[7] = '{RW_ST, LEN_WORD, 1'b0, 32'h200, 32'h5555_5555, 32'h0000_007F, 1'b1, 32'h0000_007F};
      tbl[8] = '{RW_LD, LEN_HALF, 1'b0, 32'h24, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 32'h0};
      for (int i = 0; i < 9; i++) run_access(tbl[i], $sformatf("vec%0d", i));

      // Early response: offered during REQ, must wait for WAIT
      dmem.dmemreq_rdy = 1'b0;
      dmem.dmemresp_val = 1'b1; dmem.dmemresp_msg_data = 32'h1357_2468;
      start_req(RW_LD, LEN_WORD, 1'b0, 32'h500, 32'h1357_2468);
      for (int k = 0; k < 2; k++) begin
         check("early_resp_rdy", {30'd0, dmem.dmemresp_rdy, busy}, 32'd1);
         step();
      end
      dmem.dmemreq_rdy = 1'b1;
      step();
      check("early_wait", {30'd0, dmem.dmemresp_rdy, done}, 32'd2);
      step();
      check("early_done", {31'd0, done}, 32'd1);
      dmem.dmemresp_val = 1'b0;
      sb_pop_check("early");
      step();

      // Same-cycle start and nibble write at offset 7
      st_nib_en = 1'b1; st_off = 3'd7; st_nib = 4'hA;
      start_req(RW_ST, LEN_WORD, 1'b0, 32'h600, 32'hA357_2468);
      st_nib_en = 1'b0;
      check("same_top_nib", {28'd0, dmem.dmemreq_msg_data[31:28]}, 32'hA);
      check("same_word", dmem.dmemreq_msg_data, 32'hA357_2468);
      dmem.dmemresp_val = 1'b1; dmem.dmemresp_msg_data = 32'h0;
      wait_done("same", n);
      dmem.dmemresp_val = 1'b0;
      sb_pop_check("same");
      step();

      // Reset during WAIT, then a fresh load
      dmem.dmemreq_rdy = 1'b1; dmem.dmemresp_val = 1'b0;
      req_rw = RW_LD; req_len = LEN_WORD; req_unsigned = 1'b0; req_addr = 32'h700;
      req_start = 1'b1;
      step();
      req_start = 1'b0;
      step();
      check("rstw_in_wait", {30'd0, dmem.dmemresp_rdy, busy}, 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check("rstw_outputs", {28'd0, busy, done, dmem.dmemreq_val, dmem.dmemresp_rdy}, 32'd0);
      read_buf(w);
      check("rstw_buffer", w, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      v = '{rw: RW_LD, len: LEN_BYTE, uns: 1'b1, addr: 32'h704, resp: 32'h0000_0080,
            exp_word: 32'h0000_0080, chk_data: 1'b0, exp_data: 32'h0};
      run_access(v, "post_reset");

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
